uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter; the counterpart of the existing uart_rx.
- Sends status and telemetry bytes (alarm events, distance readings, relay and servo state) from the top level to the host or Bluetooth module on the serial line.
- Producers push bytes through a valid/ready handshake into an internal FIFO.
- A bit-timing FSM drains the FIFO back-to-back onto `tx`.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- FIFO_DEPTH, 16: FIFO entries; must be a power of two, minimum 2.
- Derived (localparam): BAUD_DIV = CLK_FREQ/BAUD, integer divide, truncated (5208 at defaults). Every bit period is exactly BAUD_DIV clk cycles.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- data_i  input  8  byte to transmit.
- valid_i  input  1  data_i valid; a byte is accepted on the rising edge where valid_i && ready_o.
- ready_o  output  1  FIFO not full.
- tx  output  1  serial line; idles high.
- busy_o  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Interface decided: one clock, clk; reset rst is synchronous and active-high.
- Reset values (registered, take effect at the first clk edge with rst=1):
  - tx=1, ready_o=1, busy_o=0, fifo_count_o=0.
  - FIFO pointers cleared, FSM=IDLE, baud and bit counters cleared.
- Reset mid-frame:
  - The frame is aborted and tx returns to 1 on that edge.
  - The FIFO is flushed and no partial bits continue after reset is released.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address.
  - ready_o = !full, combinational from the pointers.
  - Writes while full are impossible, because ready_o=0 means the handshake does not fire.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pop on an empty FIFO never happens.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the option below is enabled).
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, load baud_cnt=0, go to START.
  - START: tx=0 for BAUD_DIV cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift[bit_idx], LSB first, each bit for BAUD_DIV cycles. After bit 7, go to STOP (or PARITY).
  - STOP: tx=1 for BAUD_DIV cycles. Then:
    - if the FIFO is non-empty, pop and go directly to START (no extra idle cycle between frames);
    - otherwise go to IDLE.
- Latency: a byte accepted at edge k into an empty FIFO with the FSM in IDLE is popped at edge k+1, and tx falls at edge k+1 (tx is registered from the next state).
- Baud counter: counts 0..BAUD_DIV-1 and wraps at the bit boundary. Frame length is 10*BAUD_DIV cycles (11 with parity).
- busy_o = (state != IDLE) || (count != 0), registered.
- The shift register is loaded only on pop; data_i may change freely after acceptance.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for BAUD_DIV cycles.
  - Frame is 8E1, 11 bit periods.
- Undefined:
  - No PARITY state exists; frame is 8N1, 10 bit periods.
  - Logic is otherwise identical.

Test Plan (CLK_FREQ=1_000_000, BAUD=100_000, so BAUD_DIV=10; FIFO_DEPTH=4):
1. Reset held 3 cycles, then released with valid_i=0 -> tx=1, ready_o=1, busy_o=0, fifo_count_o=0 for 200 cycles.
2. Push 0x55 at edge k -> tx low for edges k+1..k+10. Then data bits 1,0,1,0,1,0,1,0, 10 cycles each. Then stop high for 10 cycles. Then busy_o=0; total 100 cycles.
3. Push 0xA3, 0x0F, 0xFF on consecutive cycles -> frames back-to-back with no idle gap. The bench-side receiver decodes 0xA3, 0x0F, 0xFF in order; fifo_count_o peaks at 2.
4. Hold valid_i=1 with bytes 0x01..0x08 -> ready_o falls when count reaches 4. Only bytes taken on handshake edges are transmitted, in order, none lost or duplicated; ready_o rises within 1 cycle of each pop.
5. Push 0x3C, then assert rst for 1 cycle at cycle 35 (mid-DATA) -> tx=1 at the next edge, fifo_count_o=0, no further falling edge on tx.
6. With UART_TX_PARITY_EN, push 0x07 (three 1s) -> parity bit = 1 during bit period 10, stop bit in period 11, frame 110 cycles. Without the macro: 100 cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
// Producers push bytes through a valid/ready handshake into a circular FIFO;
// a bit-timing FSM drains the FIFO back-to-back onto tx, LSB first.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit (8E1 frames).
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;
  localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  // FIFO storage and pointers (one bit wider than the address to tell full from empty)
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  // Transmitter state
  state_t        state_reg, state_next;
  logic [BW-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_data_reg;
  logic          tx_reg, tx_next;
  logic          busy_reg, busy_next;
  logic          baud_tick;

  assign count      = wr_ptr_reg - rd_ptr_reg;
  assign empty      = (count == '0);
  assign full       = (count == DEPTH_CNT);
  assign push       = valid_i && !full;
  assign count_next = count + CW'(push) - CW'(pop);
  assign baud_tick  = (baud_cnt_reg == BAUD_LAST);

  assign ready_o      = !full;
  assign tx           = tx_reg;
  assign busy_o       = busy_reg;
  assign fifo_count_o = count;

  // FIFO write port; no reset so the array can map onto block RAM
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= data_i;
    end
  end

  // FIFO pointers; reset flushes any queued bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Registered read of the FIFO head into the shift register, only on pop
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_data_reg <= '0;
    end else if (pop) begin
      shift_data_reg <= mem[rd_ptr_reg[AW-1:0]];
    end
  end

  // State register plus registered line and busy outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
    end
  end

  // Next-state logic: bit timing, bit sequencing and FIFO pops
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_tick ? '0 : baud_cnt_reg + 1'b1;
    bit_idx_next  = bit_idx_reg;
    pop           = 1'b0;
    case (state_reg)
      S_IDLE: begin
        baud_cnt_next = '0;
        bit_idx_next  = '0;
        if (!empty) begin
          pop        = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          bit_idx_next = '0;
          state_next   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bit_idx_reg == 3'd7) begin
            bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next   = S_PARITY;
`else
            state_next   = S_STOP;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_tick) begin
          state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_tick) begin
          // Chain straight into the next frame when more data is queued
          if (!empty) begin
            pop        = 1'b1;
            state_next = S_START;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: begin
        baud_cnt_next = '0;
        bit_idx_next  = '0;
        state_next    = S_IDLE;
      end
    endcase
  end

  // Output logic: line level and busy derived from the upcoming state
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_data_reg[bit_idx_next];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_next = ^shift_data_reg;
`endif
      default:  tx_next = 1'b1;
    endcase
    busy_next = (state_next != S_IDLE) || (count_next != '0);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo (BAUD_DIV=10, FIFO_DEPTH=4).
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CLK_FREQ   = 1_000_000;
  localparam int BAUD       = 100_000;
  localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FL  = 110;
  localparam bit PAR = 1'b1;
`else
  localparam int FL  = 100;
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic       tx;
  logic       busy_o;
  logic [2:0] fifo_count_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  uart_tx_fifo #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_i(data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .tx(tx),
    .busy_o(busy_o),
    .fifo_count_o(fifo_count_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=time limit reached expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level i edges after the push edge of a lone byte
  function automatic logic exp_tx(input logic [7:0] b, input int i);
    if (i >= 1 && i <= 10) return 1'b0;
    if (i >= 11 && i <= 90) return b[(i - 11) / 10];
    if (PAR && i >= 91 && i <= 100) return ^b;
    return 1'b1;
  endfunction

  // Bench-side receiver: find the start bit, sample every bit mid-period
  task automatic rx_byte(output logic [7:0] b, output int s, output bit ok);
    b = 8'h00;
    s = -1;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      s = cyc;
      repeat (5) tick();
      for (int j = 0; j < 8; j++) begin
        repeat (10) tick();
        b[j] = tx;
      end
      if (PAR) begin
        repeat (10) tick();
        check("rx_parity", 32'(tx), 32'(^b));
      end
      repeat (10) tick();
      check("rx_stop", 32'(tx), 32'd1);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (busy_o === 1'b0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_idle"}, 32'(done), 32'd1);
  endtask

  // Push one byte into an idle transmitter and check the whole frame
  task automatic frame_check(input logic [7:0] b, input string tag);
    int bad;
    bad = 0;
    data_i = b;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    data_i = 8'h00;
    check({tag, "_cnt_after_push"}, 32'(fifo_count_o), 32'd1);
    check({tag, "_busy_after_push"}, 32'(busy_o), 32'd1);
    check({tag, "_tx_after_push"}, 32'(tx), 32'd1);
    for (int i = 1; i <= FL + 1; i++) begin
      tick();
      if (tx !== exp_tx(b, i)) bad++;
      if (i == 1) begin
        check({tag, "_start_edge"}, 32'(tx), 32'd0);
        check({tag, "_cnt_after_pop"}, 32'(fifo_count_o), 32'd0);
      end
      if (i == 10) check({tag, "_start_last"}, 32'(tx), 32'd0);
      if (i == 11) check({tag, "_bit0"}, 32'(tx), 32'(b[0]));
      if (i == 21) check({tag, "_bit1"}, 32'(tx), 32'(b[1]));
      if (i == 96) check({tag, "_after_data"}, 32'(tx), 32'(PAR ? ^b : 1'b1));
      if (i == FL) check({tag, "_busy_last"}, 32'(busy_o), 32'd1);
      if (i == FL + 1) begin
        check({tag, "_busy_end"}, 32'(busy_o), 32'd0);
        check({tag, "_tx_end"}, 32'(tx), 32'd1);
      end
    end
    check({tag, "_frame_bits_bad"}, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] s3_bytes [3];
    int         st [8];
    bit         ok;
    int         bad;
    int         peak;
    int         idx;
    int         t0;
    int         first_full;
    int         incons;
    int         guard;
    int         falls;
    logic       r;
    logic       prev_tx;

    s3_bytes[0] = 8'hA3;
    s3_bytes[1] = 8'h0F;
    s3_bytes[2] = 8'hFF;

    // Step 1: reset and quiet line
    rst = 1'b1;
    tick();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_count", 32'(fifo_count_o), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx !== 1'b1 || ready_o !== 1'b1 || busy_o !== 1'b0 || fifo_count_o !== 3'd0) bad++;
    end
    check("idle_200_bad_cycles", 32'(bad), 32'd0);

    // Step 2: single 0x55 frame
    frame_check(8'h55, "s2");

    // Step 3: three consecutive pushes, back-to-back frames
    peak = 0;
    fork
      begin
        data_i = 8'hA3; valid_i = 1'b1;
        tick();
        data_i = 8'h0F;
        tick();
        data_i = 8'hFF;
        tick();
        valid_i = 1'b0;
        data_i = 8'h00;
      end
      begin
        for (int k = 0; k < 3; k++) begin
          rx_byte(rb, st[k], ok);
          check("s3_rx_found", 32'(ok), 32'd1);
          check("s3_rx_byte", 32'(rb), 32'(s3_bytes[k]));
        end
      end
      begin
        repeat (40) begin
          @(negedge clk);
          if (int'(fifo_count_o) > peak) peak = int'(fifo_count_o);
        end
      end
    join
    check("s3_gap_1_2", 32'(st[1] - st[0]), 32'(FL));
    check("s3_gap_2_3", 32'(st[2] - st[1]), 32'(FL));
    check("s3_peak_count", 32'(peak), 32'd2);
    wait_idle("s3");

    // Step 4: hold valid through backpressure with bytes 0x01..0x08
    idx = 0; t0 = -1; first_full = -1; incons = 0; guard = 0;
    fork
      begin
        while (idx < 8 && guard < 2000) begin
          data_i = 8'(idx + 1);
          valid_i = 1'b1;
          r = ready_o;
          if (r !== 1'b1 && first_full < 0) begin
            first_full = cyc;
            check("s4_full_count", 32'(fifo_count_o), 32'd4);
          end
          if (r !== (fifo_count_o != 3'd4)) incons++;
          tick();
          guard++;
          if (r === 1'b1) begin
            if (idx == 0) t0 = cyc;
            idx++;
          end
        end
        valid_i = 1'b0;
        data_i = 8'h00;
      end
      begin
        for (int k = 0; k < 8; k++) begin
          rx_byte(rb, st[k], ok);
          check("s4_rx_found", 32'(ok), 32'd1);
          check("s4_rx_byte", 32'(rb), 32'(k + 1));
        end
      end
    join
    check("s4_all_accepted", 32'(idx), 32'd8);
    check("s4_full_after", 32'(first_full - t0), 32'd4);
    check("s4_ready_vs_count", 32'(incons), 32'd0);
    wait_idle("s4");
    check("s4_count_end", 32'(fifo_count_o), 32'd0);

    // Step 5: reset mid-frame aborts and flushes
    data_i = 8'h3C; valid_i = 1'b1;
    tick();
    data_i = 8'h99;
    tick();
    valid_i = 1'b0;
    data_i = 8'h00;
    repeat (24) tick();
    check("s5_mid_bit1", 32'(tx), 32'd0);
    check("s5_queued", 32'(fifo_count_o), 32'd1);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    check("s5_rst_tx", 32'(tx), 32'd1);
    check("s5_rst_count", 32'(fifo_count_o), 32'd0);
    check("s5_rst_busy", 32'(busy_o), 32'd0);
    check("s5_rst_ready", 32'(ready_o), 32'd1);
    rst = 1'b0;
    falls = 0; bad = 0; prev_tx = tx;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (prev_tx === 1'b1 && tx === 1'b0) falls++;
      if (busy_o !== 1'b0 || fifo_count_o !== 3'd0) bad++;
      prev_tx = tx;
    end
    check("s5_no_falling_edge", 32'(falls), 32'd0);
    check("s5_stays_idle", 32'(bad), 32'd0);

    // Step 6: 0x07 frame, parity bit when enabled
    frame_check(8'h07, "s6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
